stepper_step_gen: RTL and testbench
===================================

STEPPER_STEP_GEN -- requirements
Module: stepper_step_gen

Interface
REQ-001 SHALL have parameter PULSE_W, default 50: STEP high width in FAB_CLK cycles.
REQ-002 SHALL have parameter DIR_SETUP, default 20: DIR-to-first-STEP setup in cycles.
REQ-003 SHALL have parameter RAMP_STEP, default 16: per-step period decrement in ramp mode.
REQ-004 SHALL have ports, in this order:
- FAB_CLK  in  1  single clock, from the CCC fabric clock output; rising edge.
- RESET  in  1  synchronous, active-high.
- FAB_LOCK  in  1  CCC lock; 0 means the clock is not trusted.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  command accepted when both VALID and READY are 1.
- CMD_STEPS  in  16  step count.
- CMD_DIR  in  1  direction.
- CMD_PERIOD  in  16  cycles per step.
- ABORT  in  1  stop request.
- STEP  out  1  step pulse.
- DIR  out  1  direction output.
- BUSY  out  1  move in progress.
- DONE  out  1  one-cycle completion pulse.
- FAULT  out  1  sticky lock-loss flag.
- POSITION  out  32  signed step position.

Function
REQ-005 SHALL implement an FSM with states IDLE, SETUP, PULSE_HI, PULSE_LO.
REQ-006 CMD_READY SHALL equal (state==IDLE && FAB_LOCK).
REQ-007 On accept, the block SHALL:
- latch DIR=CMD_DIR, steps and effective period;
- clear FAULT;
- go to SETUP.
REQ-008 Effective period SHALL be max(CMD_PERIOD, 2*PULSE_W), computed 17 bits wide.
REQ-009 If CMD_STEPS==0 on accept, the block SHALL skip SETUP, pulse DONE the next cycle and return to IDLE with no STEP.
REQ-010 SETUP SHALL last DIR_SETUP cycles, then go to PULSE_HI.
REQ-011 PULSE_HI SHALL hold STEP=1 for PULSE_W cycles.
REQ-012 On entry to PULSE_HI, POSITION SHALL change by +1 if DIR=1 and by -1 if DIR=0, wrapping two's complement.
REQ-013 PULSE_LO SHALL last (period - PULSE_W) cycles. It SHALL then:
- decrement the remaining count;
- go to PULSE_HI if the count is nonzero;
- otherwise go to IDLE with DONE=1 for one cycle.
REQ-014 STEP-to-STEP rising-edge spacing SHALL equal the effective period exactly.
REQ-015 ABORT outside PULSE_HI SHALL take the FSM to IDLE next cycle with DONE=1.
REQ-016 ABORT in PULSE_HI SHALL let the high phase complete, then go to IDLE with DONE=1; no further STEP.
REQ-017 FAB_LOCK=0 in any non-IDLE state SHALL give, the next cycle:
- STEP=0;
- state IDLE;
- FAULT=1;
- no DONE.
REQ-018 If FAB_LOCK falls and ABORT is asserted in the same cycle, lock loss SHALL take priority.
REQ-019 BUSY SHALL be 1 in every state except IDLE.
REQ-020 All outputs SHALL be registered.
REQ-021 CMD_* SHALL be ignored while BUSY.
REQ-022 DIR SHALL hold its last value in IDLE.

Reset
REQ-023 When RESET=1 the block SHALL set:
- state IDLE;
- STEP=0, DIR=0, BUSY=0, DONE=0, FAULT=0;
- POSITION=0;
- internal counters 0.
REQ-024 RESET mid-move SHALL abandon the move without a DONE pulse.
REQ-025 CMD_READY SHALL be 0 during RESET.

Configuration
REQ-026 With macro STEPPER_RAMP_EN defined, the block SHALL apply a start ramp:
- the first step's period is 2*effective period;
- each subsequent period is reduced by RAMP_STEP, floored at the effective period;
- PULSE_HI width is unchanged.
REQ-027 Without STEPPER_RAMP_EN, every period SHALL equal the effective period, and no ramp logic SHALL be synthesised.

Structure
REQ-028 A shared package stepper_pkg SHALL hold:
- the state enum;
- POSITION width (32);
- count width (16);
- period width (16).
REQ-029 A sub-module stepper_period_ctr SHALL be used: a loadable down-counter with terminal-count flag, shared by the SETUP, PULSE_HI and PULSE_LO timing.

Verification
REQ-030 Basic move: CMD_STEPS=3, DIR=1, PERIOD=200, lock=1 -> 3 STEP pulses 50 cycles high, rising edges 200 apart, first edge 20 cycles after accept, POSITION=3, one DONE.
REQ-031 Period clamp: CMD_PERIOD=40, PULSE_W=50 -> edge spacing 100, POSITION decrements by CMD_STEPS when DIR=0.
REQ-032 Zero steps: CMD_STEPS=0 -> DONE one cycle after accept, no STEP, POSITION unchanged.
REQ-033 Abort: ABORT mid-PULSE_HI of step 2 of 10 -> high phase completes, no third STEP, POSITION=+2, DONE=1.
REQ-034 Lock loss: FAB_LOCK drops in PULSE_LO of step 1 -> STEP=0, FAULT=1, no DONE, CMD_READY=0 until FAB_LOCK=1; the next accept clears FAULT.
REQ-035 Ramp (STEPPER_RAMP_EN defined): PERIOD=200, steps=4, RAMP_STEP=16 -> edge spacings 400, 384, 368.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared types and widths for the stepper step generator.
package stepper_pkg;

  localparam int unsigned POS_W = 32;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned PER_W = 16;
  localparam int unsigned EFF_W = PER_W + 1;
  localparam int unsigned CTR_W = PER_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE_HI,
    PULSE_LO
  } state_t;

endpackage

// File: rtl/stepper_period_ctr.sv
// Loadable down-counter with terminal-count flag; times SETUP, PULSE_HI and PULSE_LO.
module stepper_period_ctr
  import stepper_pkg::*;
#(
  parameter int unsigned W = CTR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tc_c = (count == '0);

endmodule

// File: rtl/stepper_step_gen.sv
// Step/direction pulse generator with DIR setup, abort and lock-loss handling.
// Define STEPPER_RAMP_EN to build in the start ramp (first period doubled, then shortened per step).
module stepper_step_gen
  import stepper_pkg::*;
#(
  parameter int unsigned PULSE_W   = 50,
  parameter int unsigned DIR_SETUP = 20,
  parameter int unsigned RAMP_STEP = 16
) (
  input  logic             FAB_CLK,
  input  logic             RESET,
  input  logic             FAB_LOCK,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [CNT_W-1:0] CMD_STEPS,
  input  logic             CMD_DIR,
  input  logic [PER_W-1:0] CMD_PERIOD,
  input  logic             ABORT,
  output logic             STEP,
  output logic             DIR,
  output logic             BUSY,
  output logic             DONE,
  output logic             FAULT,
  output logic [POS_W-1:0] POSITION
);

  state_t           state, state_d;
  logic [CNT_W-1:0] steps_q, steps_d, steps_dec;
  logic [CTR_W-1:0] per_q, per_d, per_start_c, per_next_c;
  logic [EFF_W-1:0] eff_c;
  logic [POS_W-1:0] pos_q, pos_d, pos_step_c;
  logic             dir_q, dir_d, fault_q, fault_d, abort_q, abort_d, done_d;
  logic             step_q, busy_q, done_q;
  logic             accept, ld, tc;
  logic [CTR_W-1:0] ld_val;

  // Ready gates registered state with live lock so a lock drop blocks accept at once.
  assign CMD_READY  = (state == IDLE) && FAB_LOCK && !RESET;
  assign accept     = CMD_READY && CMD_VALID;
  assign eff_c      = ({1'b0, CMD_PERIOD} > EFF_W'(2 * PULSE_W)) ? {1'b0, CMD_PERIOD}
                                                                  : EFF_W'(2 * PULSE_W);
  assign steps_dec  = steps_q - CNT_W'(1);
  assign pos_step_c = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);

`ifdef STEPPER_RAMP_EN
  logic [EFF_W-1:0] floor_q;

  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      floor_q <= '0;
    end else if (accept) begin
      floor_q <= eff_c;
    end
  end

  assign per_start_c = {eff_c, 1'b0};
  assign per_next_c  = (per_q >= CTR_W'(floor_q) + CTR_W'(RAMP_STEP))
                       ? per_q - CTR_W'(RAMP_STEP) : CTR_W'(floor_q);
`else
  assign per_start_c = CTR_W'(eff_c);
  assign per_next_c  = per_q;

  // RAMP_STEP shapes only the ramp build.
  if (RAMP_STEP != 0) begin : g_flat_period
  end
`endif

  stepper_period_ctr #(.W(CTR_W)) u_ctr (
    .clk      (FAB_CLK),
    .reset    (RESET),
    .load     (ld),
    .load_val (ld_val),
    .tc_c     (tc)
  );

  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      state   <= IDLE;
      steps_q <= '0;
      per_q   <= '0;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      fault_q <= 1'b0;
      abort_q <= 1'b0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      steps_q <= steps_d;
      per_q   <= per_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      fault_q <= fault_d;
      abort_q <= abort_d;
      step_q  <= (state_d == PULSE_HI);
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    steps_d = steps_q;
    per_d   = per_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    fault_d = fault_q;
    abort_d = abort_q;
    done_d  = 1'b0;
    ld      = 1'b0;
    ld_val  = '0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          dir_d   = CMD_DIR;
          fault_d = 1'b0;
          abort_d = 1'b0;
          steps_d = CMD_STEPS;
          per_d   = per_start_c;
          if (CMD_STEPS == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = SETUP;
            ld      = 1'b1;
            ld_val  = CTR_W'(DIR_SETUP - 1);
          end
        end
      end
      SETUP: begin
        if (tc) begin
          state_d = PULSE_HI;
          pos_d   = pos_step_c;
          ld      = 1'b1;
          ld_val  = CTR_W'(PULSE_W - 1);
        end
      end
      PULSE_HI: begin
        if (ABORT) abort_d = 1'b1;
        if (tc) begin
          if (abort_d) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = PULSE_LO;
            ld      = 1'b1;
            ld_val  = per_q - CTR_W'(PULSE_W) - CTR_W'(1);
          end
        end
      end
      PULSE_LO: begin
        if (tc) begin
          steps_d = steps_dec;
          if (steps_dec != '0) begin
            state_d = PULSE_HI;
            pos_d   = pos_step_c;
            per_d   = per_next_c;
            ld      = 1'b1;
            ld_val  = CTR_W'(PULSE_W - 1);
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort outside the high phase ends the move immediately.
    if ((state == SETUP || state == PULSE_LO) && ABORT) begin
      state_d = IDLE;
      done_d  = 1'b1;
      pos_d   = pos_q;
      ld      = 1'b0;
    end

    // Lock loss outranks everything: drop the move silently and flag it.
    if (state != IDLE && !FAB_LOCK) begin
      state_d = IDLE;
      done_d  = 1'b0;
      fault_d = 1'b1;
      abort_d = 1'b0;
      pos_d   = pos_q;
      ld      = 1'b0;
    end
  end

  assign STEP     = step_q;
  assign DIR      = dir_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign FAULT    = fault_q;
  assign POSITION = pos_q;

endmodule

// File: tb/tb_stepper_step_gen.sv
// Scoreboard bench for stepper_step_gen: expected STEP edges and DONE pulses are queued at accept.
module tb_stepper_step_gen;

  localparam int PW = 50;

  logic        FAB_CLK = 1'b0;
  logic        RESET, FAB_LOCK, CMD_VALID, CMD_READY, CMD_DIR, ABORT;
  logic        STEP, DIR, BUSY, DONE, FAULT;
  logic [15:0] CMD_STEPS, CMD_PERIOD;
  logic [31:0] POSITION;

  typedef enum int {EV_STEP, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
    int       pos;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hi_start = 0;
  logic step_prev = 1'b0;

  stepper_step_gen dut (
    .FAB_CLK    (FAB_CLK),
    .RESET      (RESET),
    .FAB_LOCK   (FAB_LOCK),
    .CMD_VALID  (CMD_VALID),
    .CMD_READY  (CMD_READY),
    .CMD_STEPS  (CMD_STEPS),
    .CMD_DIR    (CMD_DIR),
    .CMD_PERIOD (CMD_PERIOD),
    .ABORT      (ABORT),
    .STEP       (STEP),
    .DIR        (DIR),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .FAULT      (FAULT),
    .POSITION   (POSITION)
  );

  always #5 FAB_CLK = ~FAB_CLK;
  always @(posedge FAB_CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input ev_kind_t k, input int c, input int p);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.pos  = p;
    exp_q.push_back(e);
  endtask

  task automatic sb_match(input ev_kind_t k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got %s at cyc %0d pos %0d, expected no event", k.name(), cyc, $signed(POSITION));
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.pos != $signed(POSITION)) begin
        errors++;
        $display("FAIL sb_event: got %s cyc %0d pos %0d, expected %s cyc %0d pos %0d",
                 k.name(), cyc, $signed(POSITION), e.kind.name(), e.cyc, e.pos);
      end
    end
  endtask

  // Monitor: STEP rising edges, STEP high width and DONE pulses.
  always @(negedge FAB_CLK) begin
    if (!RESET) begin
      if (STEP && !step_prev) begin
        hi_start = cyc;
        sb_match(EV_STEP);
      end
      if (!STEP && step_prev) check("step_width", 32'(cyc - hi_start), 32'(PW));
      if (DONE) sb_match(EV_DONE);
    end
    step_prev = STEP;
  end

  task automatic issue_cmd(input int steps, input logic dir, input int period, output int a);
    @(negedge FAB_CLK);
    CMD_VALID  = 1'b1;
    CMD_STEPS  = 16'(steps);
    CMD_DIR    = dir;
    CMD_PERIOD = 16'(period);
    check("ready_at_offer", 32'(CMD_READY), 32'd1);
    @(posedge FAB_CLK);
    #1 a = cyc;
    @(negedge FAB_CLK);
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge FAB_CLK);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge FAB_CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d events pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (30) @(negedge FAB_CLK);
  endtask

  initial begin
    int a;
    RESET = 1'b1; FAB_LOCK = 1'b1; CMD_VALID = 1'b0; CMD_DIR = 1'b0; ABORT = 1'b0;
    CMD_STEPS = '0; CMD_PERIOD = '0;
    repeat (3) @(negedge FAB_CLK);
    check("ready_in_reset", 32'(CMD_READY), 32'd0);
    check("reset_outputs", {26'd0, STEP, DIR, BUSY, DONE, FAULT, 1'b0}, 32'd0);
    check("reset_position", POSITION, 32'd0);
    RESET = 1'b0;
    @(negedge FAB_CLK);
    check("ready_after_reset", 32'(CMD_READY), 32'd1);

    // Basic move; a competing command mid-move must be ignored.
    issue_cmd(3, 1'b1, 200, a);
    push(EV_STEP, a + 20, 1); push(EV_STEP, a + 220, 2); push(EV_STEP, a + 420, 3);
    push(EV_DONE, a + 620, 3);
    wait_until(a + 50);
    CMD_VALID = 1'b1; CMD_STEPS = 16'd7; CMD_DIR = 1'b0;
    check("busy_mid_move", 32'(BUSY), 32'd1);
    check("ready_mid_move", 32'(CMD_READY), 32'd0);
    repeat (3) @(negedge FAB_CLK);
    CMD_VALID = 1'b0;
    wait_drain("basic", 900);
    check("basic_pos", POSITION, 32'd3);
    check("basic_dir_hold", 32'(DIR), 32'd1);
    check("basic_idle", 32'(BUSY), 32'd0);

    // Period clamp to 2*PULSE_W, reverse direction.
    issue_cmd(2, 1'b0, 40, a);
    push(EV_STEP, a + 20, 2); push(EV_STEP, a + 120, 1); push(EV_DONE, a + 220, 1);
    wait_drain("clamp", 400);
    check("clamp_pos", POSITION, 32'd1);
    check("clamp_dir_hold", 32'(DIR), 32'd0);

    // Zero steps.
    issue_cmd(0, 1'b1, 200, a);
    push(EV_DONE, a, 1);
    wait_drain("zero", 10);
    check("zero_pos", POSITION, 32'd1);
    check("zero_dir", 32'(DIR), 32'd1);

    // Abort during the second high phase.
    issue_cmd(10, 1'b1, 200, a);
    push(EV_STEP, a + 20, 2); push(EV_STEP, a + 220, 3); push(EV_DONE, a + 270, 3);
    wait_until(a + 230);
    ABORT = 1'b1;
    @(negedge FAB_CLK);
    ABORT = 1'b0;
    wait_drain("abort_hi", 400);
    check("abort_hi_pos", POSITION, 32'd3);

    // Abort during SETUP.
    issue_cmd(5, 1'b1, 200, a);
    push(EV_DONE, a + 6, 3);
    wait_until(a + 5);
    ABORT = 1'b1;
    @(negedge FAB_CLK);
    ABORT = 1'b0;
    wait_drain("abort_setup", 50);

    // Lock loss in PULSE_LO of step 1.
    issue_cmd(3, 1'b1, 200, a);
    push(EV_STEP, a + 20, 4);
    wait_until(a + 100);
    FAB_LOCK = 1'b0;
    @(negedge FAB_CLK);
    check("lock_fault", 32'(FAULT), 32'd1);
    check("lock_step", 32'(STEP), 32'd0);
    check("lock_busy", 32'(BUSY), 32'd0);
    check("lock_ready", 32'(CMD_READY), 32'd0);
    CMD_VALID = 1'b1;
    repeat (20) @(negedge FAB_CLK);
    check("lock_ready_held", 32'(CMD_READY), 32'd0);
    CMD_VALID = 1'b0;
    FAB_LOCK = 1'b1;
    #1 check("lock_ready_back", 32'(CMD_READY), 32'd1);
    check("lock_fault_sticky", 32'(FAULT), 32'd1);
    wait_drain("lock", 10);
    issue_cmd(0, 1'b1, 200, a);
    push(EV_DONE, a, 4);
    check("lock_fault_cleared", 32'(FAULT), 32'd0);
    wait_drain("lock_clear", 10);

    // Lock loss and abort together: lock loss wins, no DONE.
    issue_cmd(3, 1'b1, 200, a);
    wait_until(a + 5);
    FAB_LOCK = 1'b0; ABORT = 1'b1;
    @(negedge FAB_CLK);
    FAB_LOCK = 1'b1; ABORT = 1'b0;
    check("prio_fault", 32'(FAULT), 32'd1);
    check("prio_done", 32'(DONE), 32'd0);
    check("prio_busy", 32'(BUSY), 32'd0);
    wait_drain("prio", 10);

    // Four steps: ramp build shortens periods, flat build keeps them equal.
    issue_cmd(4, 1'b1, 200, a);
`ifdef STEPPER_RAMP_EN
    push(EV_STEP, a + 20, 5); push(EV_STEP, a + 420, 6); push(EV_STEP, a + 804, 7);
    push(EV_STEP, a + 1172, 8); push(EV_DONE, a + 1524, 8);
`else
    push(EV_STEP, a + 20, 5); push(EV_STEP, a + 220, 6); push(EV_STEP, a + 420, 7);
    push(EV_STEP, a + 620, 8); push(EV_DONE, a + 820, 8);
`endif
    wait_drain("four_step", 2000);
    check("four_step_pos", POSITION, 32'd8);

    // Reset mid-move: no DONE, everything cleared.
    issue_cmd(5, 1'b1, 200, a);
    push(EV_STEP, a + 20, 9);
    wait_until(a + 100);
    RESET = 1'b1;
    @(negedge FAB_CLK);
    check("rst_ready", 32'(CMD_READY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    @(negedge FAB_CLK);
    RESET = 1'b0;
    check("rst_pos", POSITION, 32'd0);
    check("rst_outputs", {27'd0, STEP, DIR, BUSY, FAULT, 1'b0}, 32'd0);
    wait_drain("rst", 10);
    repeat (600) @(negedge FAB_CLK);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
